// File: rtl/cam_frame_writer_pkg.sv
// Shared constants for the camera frame writer: FSM state encoding,
// RGB444 byte field helpers and the pixel-count formula.
package cam_frame_writer_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    EXPECT_HI  = 2'd1,
    EXPECT_LO  = 2'd2
  } cam_state_e;

  // Byte 1 carries red in its low nibble; byte 2 carries {G,B}.
  localparam int PX_R_MSB  = 3;
  localparam int RGB444_W  = 12;

  function automatic logic [3:0] px_red(input logic [7:0] b);
    return b[PX_R_MSB:0];
  endfunction

  function automatic logic [RGB444_W-1:0] pack_rgb444(input logic [3:0] r,
                                                      input logic [7:0] gb);
    return {r, gb};
  endfunction

  function automatic int npix(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/cam_frame_writer_edge_det.sv
// Registers a single-bit input and reports its rising and falling edges
// relative to the registered copy.
module cam_frame_writer_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;
  logic sig_d;

  // Next value of the delayed copy is simply the current input.
  always_comb begin
    sig_d = sig;
  end

  // One-cycle delay register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig_d;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/cam_frame_writer.sv
// Captures OV7670 RGB444 pixels (two bytes per pixel, framed by vsync/href)
// and issues one frame-buffer write per pixel. Also reports, at the end of
// each frame, whether the frame held exactly NPIX pixels without faults.
//
// Handshake: there is no back-pressure. regwrite is a one-cycle strobe; the
// buffer must accept addr_in/data_in on every cycle regwrite is high.
// A pixel's second byte consumed at edge N yields regwrite high after N+1.
module cam_frame_writer
  import cam_frame_writer_pkg::*;
#(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          frame_err
);

  localparam int          NPIX   = npix(IMG_W, IMG_H);
  localparam logic [AW:0] NPIX_C = (AW+1)'(NPIX);
  localparam logic [AW:0] ONE_C  = (AW+1)'(1);

  logic vs_rise;
  logic vs_fall;

  cam_frame_writer_edge_det u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (vsync),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  cam_state_e    state_q,      state_d;
  logic [AW:0]   pix_cnt_q,    pix_cnt_d;
  logic          err_q,        err_d;
  logic [3:0]    r_q,          r_d;
  // Staging stage: decisions made at the byte edge, presented one edge later.
  logic          wr_req_q,     wr_req_d;
  logic [AW-1:0] wr_addr_q,    wr_addr_d;
  logic [DW-1:0] wr_data_q,    wr_data_d;
  logic          done_req_q,   done_req_d;
  logic          ferr_req_q,   ferr_req_d;
  // Output registers.
  logic          regwrite_q,   regwrite_d;
  logic [AW-1:0] addr_q,       addr_d;
  logic [DW-1:0] data_q,       data_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q,  frame_err_d;

  // Next-state, pixel counter, error flag and output staging.
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    err_d        = err_q;
    r_d          = r_q;
    wr_req_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_req_d   = 1'b0;
    ferr_req_d   = 1'b0;
    regwrite_d   = wr_req_q;
    addr_d       = wr_req_q ? wr_addr_q : addr_q;
    data_d       = wr_req_q ? wr_data_q : data_q;
    frame_done_d = done_req_q;
    frame_err_d  = ferr_req_q;

    case (state_q)
      WAIT_FRAME: begin
        if (vs_fall) begin
          pix_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = EXPECT_HI;
        end
      end
      EXPECT_HI, EXPECT_LO: begin
        if (vs_rise) begin
          // End of frame wins over any byte on the bus this cycle.
          state_d = WAIT_FRAME;
          if ((pix_cnt_q == NPIX_C) && !err_q) done_req_d = 1'b1;
          else                                 ferr_req_d = 1'b1;
        end else if (state_q == EXPECT_HI) begin
          if (href) begin
            r_d     = px_red(px_data);
            state_d = EXPECT_LO;
          end
        end else begin
          state_d = EXPECT_HI;
          if (href) begin
            if (pix_cnt_q < NPIX_C) begin
              wr_req_d  = 1'b1;
              wr_addr_d = pix_cnt_q[AW-1:0];
              wr_data_d = DW'(pack_rgb444(r_q, px_data));
              pix_cnt_d = pix_cnt_q + ONE_C;
            end else begin
              // Overflow: too many pixels, counter saturates at NPIX.
              err_d = 1'b1;
            end
          end else begin
            // href dropped after byte 1: dangling half pixel.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_FRAME;
      pix_cnt_q    <= '0;
      err_q        <= 1'b0;
      r_q          <= '0;
      wr_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_req_q   <= 1'b0;
      ferr_req_q   <= 1'b0;
      regwrite_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      err_q        <= err_d;
      r_q          <= r_d;
      wr_req_q     <= wr_req_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_req_q   <= done_req_d;
      ferr_req_q   <= ferr_req_d;
      regwrite_q   <= regwrite_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign addr_in    = addr_q;
  assign data_in    = data_q;
  assign regwrite   = regwrite_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer with a 2x2 image: table-driven frames, reset
// corner cases and randomized frames checked against a frame-level model.
module tb_cam_frame_writer;

  localparam int AW    = 4;
  localparam int DW    = 12;
  localparam int IMG_W = 2;
  localparam int IMG_H = 2;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int EW    = AW + DW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b0;
  logic          href = 1'b0;
  logic [7:0]    px_data = 8'h00;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          frame_done;
  logic          frame_err;

  always #5 clk = ~clk;

  cam_frame_writer #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .regwrite   (regwrite),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- monitor (samples on falling edge) ----------------
  logic [EW-1:0] got_q[$];
  int   n_done = 0;
  int   n_err  = 0;
  int   n_long = 0;
  logic rw_prev = 1'b0;
  logic fd_prev = 1'b0;
  logic fe_prev = 1'b0;

  always @(negedge clk) begin
    if (regwrite)   got_q.push_back({addr_in, data_in});
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
    if ((regwrite && rw_prev) || (frame_done && fd_prev) || (frame_err && fe_prev))
      n_long++;
    rw_prev = regwrite;
    fd_prev = frame_done;
    fe_prev = frame_err;
  end

  // ---------------- scoreboard / model ----------------
  logic [EW-1:0] exp_q[$];
  logic [7:0]    frame_bytes[$];
  int            frame_lens[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Frame-level model: each line yields floor(len/2) pixels in order, an odd
  // line length leaves a dangling byte, pixels past NPIX are dropped.
  task automatic model_frame(output logic done);
    int            cnt = 0;
    int            idx = 0;
    logic          err = 1'b0;
    logic [7:0]    b1, b2;
    logic [AW-1:0] a;
    foreach (frame_lens[l]) begin
      for (int p = 0; p < frame_lens[l] / 2; p++) begin
        b1 = frame_bytes[idx + 2*p];
        b2 = frame_bytes[idx + 2*p + 1];
        if (cnt < NPIX) begin
          a = AW'(cnt);
          exp_q.push_back({a, b1[3:0], b2});
        end else begin
          err = 1'b1;
        end
        cnt++;
      end
      if (frame_lens[l] % 2 != 0) err = 1'b1;
      idx += frame_lens[l];
    end
    done = (cnt == NPIX) && !err;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic h, input logic [7:0] b);
    vsync   = v;
    href    = h;
    px_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    repeat (3) drive(1'b1, 1'b0, 8'h00);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
  endtask

  // Drives the loaded frame (already armed by a vsync fall), closes it with
  // a vsync pulse and compares writes and end-of-frame pulses.
  task automatic run_frame(input string name, input logic use_tbl,
                           input int tbl_writes, input logic tbl_done);
    int   base_w = got_q.size();
    int   base_d = n_done;
    int   base_e = n_err;
    int   base_l = n_long;
    int   idx = 0;
    int   exp_w;
    int   got_w;
    logic mdone;
    logic exp_done;
    exp_q.delete();
    model_frame(mdone);
    exp_w    = use_tbl ? tbl_writes : exp_q.size();
    exp_done = use_tbl ? tbl_done : mdone;
    foreach (frame_lens[l]) begin
      for (int k = 0; k < frame_lens[l]; k++) drive(1'b0, 1'b1, frame_bytes[idx + k]);
      idx += frame_lens[l];
      repeat (2) drive(1'b0, 1'b0, 8'($urandom));
    end
    vsync_pulse();
    got_w = got_q.size() - base_w;
    check({name, " writes"}, got_w, exp_w);
    for (int i = 0; i < got_w && i < exp_q.size(); i++)
      check({name, " addr/data"}, got_q[base_w + i], exp_q[i]);
    check({name, " frame_done"}, n_done - base_d, {31'd0, exp_done});
    check({name, " frame_err"},  n_err - base_e,  {31'd0, !exp_done});
    check({name, " pulse width"}, n_long - base_l, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         n_lines;
    int         len[3];
    logic [7:0] b[12];
    int         exp_writes;
    logic       exp_done;
  } vec_t;

  vec_t tbl[4];

  task automatic load_vec(input vec_t v);
    int idx = 0;
    frame_bytes.delete();
    frame_lens.delete();
    for (int l = 0; l < v.n_lines; l++) begin
      frame_lens.push_back(v.len[l]);
      for (int k = 0; k < v.len[l]; k++) frame_bytes.push_back(v.b[idx + k]);
      idx += v.len[l];
    end
  endtask

  task automatic load_random(input logic exact);
    int n;
    int len;
    frame_bytes.delete();
    frame_lens.delete();
    n = exact ? 2 : $urandom_range(1, 3);
    for (int l = 0; l < n; l++) begin
      len = exact ? 4 : $urandom_range(0, 6);
      frame_lens.push_back(len);
      for (int k = 0; k < len; k++) frame_bytes.push_back(8'($urandom));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    // Full frame, two lines of two pixels.
    tbl[0] = '{n_lines: 2, len: '{4, 4, 0},
               b: '{8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00},
               exp_writes: 4, exp_done: 1'b1};
    // Short frame: 3 pixels.
    tbl[1] = '{n_lines: 2, len: '{4, 2, 0},
               b: '{8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               exp_writes: 3, exp_done: 1'b0};
    // Long frame: 5 pixels, only 4 written.
    tbl[2] = '{n_lines: 2, len: '{4, 6, 0},
               b: '{8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'h00, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h00, 8'h00},
               exp_writes: 4, exp_done: 1'b0};
    // Dangling byte 0x05, then a correctly decoded pair.
    tbl[3] = '{n_lines: 2, len: '{1, 4, 0},
               b: '{8'h05, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               exp_writes: 2, exp_done: 1'b0};

    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    check("reset addr_in",    {28'd0, addr_in},  0);
    check("reset data_in",    {20'd0, data_in},  0);
    check("reset regwrite",   {31'd0, regwrite}, 0);
    check("reset frame_done", {31'd0, frame_done}, 0);
    check("reset frame_err",  {31'd0, frame_err},  0);
    reset = 1'b0;

    // Bytes before the first vsync pulse are ignored.
    repeat (6) drive(1'b0, 1'b1, 8'($urandom));
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    check("pre-vsync writes", got_q.size(), 0);
    check("pre-vsync pulses", n_done + n_err, 0);

    vsync_pulse();
    for (int i = 0; i < 4; i++) begin
      load_vec(tbl[i]);
      run_frame($sformatf("tbl%0d", i), 1'b1, tbl[i].exp_writes, tbl[i].exp_done);
    end

    // Reset between byte 1 and byte 2 of a pixel.
    base = got_q.size();
    drive(1'b0, 1'b1, 8'h0A);
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'hBC);
    check("midpix reset regwrite", {31'd0, regwrite}, 0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    check("midpix post regwrite", {31'd0, regwrite}, 0);
    repeat (4) drive(1'b0, 1'b1, 8'h11);
    repeat (2) drive(1'b0, 1'b0, 8'h00);
    check("midpix writes", got_q.size() - base, 0);
    vsync_pulse();
    load_vec(tbl[0]);
    run_frame("after reset", 1'b1, tbl[0].exp_writes, tbl[0].exp_done);

    // Randomized frames against the model; every third one is exact size.
    for (int r = 0; r < 24; r++) begin
      load_random(r % 3 == 0);
      run_frame($sformatf("rand%0d", r), 1'b0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
